// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM with shared timebase and boundary-synchronised double-buffered period/duty.
// Optional center-aligned (up/down) counting is compiled in when PWM_CENTER_EN is defined.
module pwm_multi #(
  parameter int N  = 8,
  parameter int CH = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  input  logic          mode,
  input  logic          load,
  input  logic [N-1:0]  period,
  input  logic [CH*N-1:0] duty,
  output logic [CH-1:0] pwm,
  output logic          sync,
  output logic          pend
);
  logic [N-1:0]    r_cnt, r_per_a, r_per_s, w_cnt_nx;
  logic [CH*N-1:0] r_duty_a, r_duty_s;
  logic [CH-1:0]   r_pwm, w_pwm_nx;
  logic            r_sync, r_pend, w_idle, w_top, w_bnd, w_xfer;
  assign w_idle = !en || (r_per_a < N'(2));
  assign w_top  = r_cnt == r_per_a - N'(1);
`ifdef PWM_CENTER_EN
  logic r_dn, w_dn_nx, w_turn;
  assign w_turn = mode && (r_dn || w_top);
  // count up to the top, then down to 1 and wrap to 0; edge mode wraps at the top
  always_comb begin
    w_cnt_nx = w_turn ? r_cnt - N'(1) : (w_top ? '0 : r_cnt + N'(1));
    w_dn_nx  = w_turn && (r_cnt != N'(1));
    w_bnd    = w_turn ? (r_cnt == N'(1)) : w_top;
  end
  // direction flag, cleared whenever the block is idle
  always_ff @(posedge clk or posedge clr)
    if (clr) r_dn <= 1'b0;
    else r_dn <= w_idle ? 1'b0 : w_dn_nx;
`else
  logic w_unused;
  assign w_unused = mode;
  // edge-aligned only: wrap to 0 after the top count
  always_comb begin
    w_cnt_nx = w_top ? '0 : r_cnt + N'(1);
    w_bnd    = w_top;
  end
`endif
  assign w_xfer = r_pend && (w_idle || w_bnd);
  // per-channel compare against the active duty
  always_comb begin
    w_pwm_nx = '0;
    for (int i = 0; i < CH; i++) w_pwm_nx[i] = !w_idle && (r_cnt < r_duty_a[i*N +: N]);
  end
  // timebase, double-buffered configuration and registered outputs
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt    <= '0;
      r_per_a  <= '0;
      r_per_s  <= '0;
      r_duty_a <= '0;
      r_duty_s <= '0;
      r_pwm    <= '0;
      r_sync   <= 1'b0;
      r_pend   <= 1'b0;
    end else begin
      r_cnt  <= w_idle ? '0 : w_cnt_nx;
      r_pwm  <= w_pwm_nx;
      r_sync <= !w_idle && (r_cnt == '0);
      r_pend <= load || (r_pend && !w_xfer);
      if (w_xfer) begin
        r_per_a  <= r_per_s;
        r_duty_a <= r_duty_s;
      end
      if (load) begin
        r_per_s  <= period;
        r_duty_s <= duty;
      end
    end
  end
  assign pwm  = r_pwm;
  assign sync = r_sync;
  assign pend = r_pend;
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: randomized and directed checks of pwm_multi against a phase-based behavioural model.
module tb_pwm_multi;
  localparam int N = 8, CH = 4;
  logic clk = 0, clr = 1, en = 0, mode = 0, load = 0;
  logic [N-1:0] period = '0;
  logic [CH*N-1:0] duty = '0;
  logic [CH-1:0] pwm;
  logic sync, pend;
  pwm_multi #(.N(N), .CH(CH)) dut (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .load(load),
    .period(period), .duty(duty), .pwm(pwm), .sync(sync), .pend(pend)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0;
  bit run_chk = 0;
  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // model: position m_k inside the current period; count value derived from it
  int m_per_a, m_per_s, m_k, m_c;
  int m_da[CH], m_ds[CH];
  bit m_pend, m_sync, m_ctr, m_idle, m_last;
  bit [CH-1:0] m_pwm;
  function automatic bit center();
`ifdef PWM_CENTER_EN
    return mode;
`else
    return 1'b0;
`endif
  endfunction
  function automatic int m_len();
    return m_ctr ? 2 * (m_per_a - 1) : m_per_a;
  endfunction
  function automatic int m_cnt();
    return (m_ctr && m_k >= m_per_a) ? 2 * (m_per_a - 1) - m_k : m_k;
  endfunction
  initial forever begin
    @(posedge clk or posedge clr);
    if (clr) begin
      m_per_a = 0; m_per_s = 0; m_k = 0; m_pend = 0; m_sync = 0; m_pwm = '0;
      for (int i = 0; i < CH; i++) begin m_da[i] = 0; m_ds[i] = 0; end
    end else begin
      m_ctr  = center();
      m_idle = !en || m_per_a < 2;
      m_c    = m_idle ? 0 : m_cnt();
      for (int i = 0; i < CH; i++) m_pwm[i] = !m_idle && (m_c < m_da[i]);
      m_sync = !m_idle && m_c == 0;
      m_last = !m_idle && m_k == m_len() - 1;
      m_k    = (m_idle || m_last) ? 0 : m_k + 1;
      if (m_pend && (m_idle || m_last)) begin
        m_per_a = m_per_s;
        for (int i = 0; i < CH; i++) m_da[i] = m_ds[i];
        m_pend = 0;
      end
      if (load) begin
        m_per_s = int'(period);
        for (int i = 0; i < CH; i++) m_ds[i] = int'(duty[i*N +: N]);
        m_pend = 1;
      end
    end
  end
  // every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (run_chk) begin
      chk("pwm", int'(pwm), int'(m_pwm));
      chk("sync", int'(sync), int'(m_sync));
      chk("pend", int'(pend), int'(m_pend));
    end
  end
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_load(int p, logic [CH*N-1:0] d);
    period = N'(p); duty = d; load = 1; tick(1); load = 0;
  endtask
  task automatic wait_cnt(int v);
    int t = 0;
    while (m_cnt() != v && t < 200) begin tick(1); t++; end
    chk("wait_cnt_timeout", int'(t < 200), 1);
  endtask
  task automatic wait_sync(output int hi0);
    int t = 0;
    hi0 = 0;
    while (sync !== 1'b1 && t < 200) begin hi0 += int'(pwm[0]); tick(1); t++; end
    chk("wait_sync_timeout", int'(t < 200), 1);
  endtask
  int h[CH], hs, hp, tmp;
  task automatic count(int n);
    for (int i = 0; i < CH; i++) h[i] = 0;
    hs = 0; hp = 0;
    repeat (n) begin
      for (int i = 0; i < CH; i++) h[i] += int'(pwm[i]);
      hs += int'(sync); hp += int'(pend);
      tick(1);
    end
  endtask
  initial begin
    @(negedge clk);
    run_chk = 1;
    tick(2);
    clr = 0;
    chk("rst_pend", int'(pend), 0);
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_sync", int'(sync), 0);
    // edge mode P=10, duties 0/3/10/12
    en = 1;
    do_load(10, {8'd12, 8'd10, 8'd3, 8'd0});
    wait_sync(tmp);
    count(10);
    chk("e_ch0", h[0], 0);
    chk("e_ch1", h[1], 3);
    chk("e_ch2", h[2], 10);
    chk("e_ch3", h[3], 10);
    chk("e_sync", hs, 1);
    tick(20);
    // glitch-free update at cnt=4
    en = 0; tick(1);
    do_load(10, {4{8'd5}});
    tick(1); en = 1;
    wait_sync(tmp);
    wait_cnt(4);
    do_load(6, {4{8'd2}});
    chk("g_pend", int'(pend), 1);
    wait_sync(tmp);
    chk("g_old_hi", tmp, 1);
    chk("g_pend_clr", int'(pend), 0);
    count(6);
    chk("g_new_hi", h[0], 2);
    chk("g_new_sync", hs, 1);
    // load on the boundary cycle
    do_load(10, {4{8'd5}});
    wait_sync(tmp); tick(1); wait_sync(tmp);
    wait_cnt(9);
    do_load(12, {4{8'd7}});
    count(10);
    chk("b_pend_hold", hp, 10);
    chk("b_pend_clr", int'(pend), 0);
    tick(30);
`ifdef PWM_CENTER_EN
    en = 0; mode = 1; tick(1);
    do_load(5, {4{8'd2}});
    tick(2); en = 1;
    wait_sync(tmp);
    count(8);
    chk("c_hi", h[0], 3);
    chk("c_sync", hs, 1);
    tick(16);
    en = 0; tick(1); mode = 0;
`endif
    // degenerate period
    en = 0; tick(1);
    do_load(1, {4{8'd1}});
    tick(2); en = 1;
    count(20);
    chk("d_pwm", h[0] + h[1] + h[2] + h[3], 0);
    chk("d_sync", hs, 0);
    // async clear mid-run with a pending load
    do_load(7, {4{8'd20}});
    tick(15);
    do_load(9, {4{8'd20}});
    #2 clr = 1;
    #1 chk("clr_pwm", int'(pwm), 0);
    chk("clr_sync", int'(sync), 0);
    chk("clr_pend", int'(pend), 0);
    tick(1); clr = 0;
    count(10);
    chk("clr_idle", h[0] + hs + hp, 0);
    // randomized run
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        period = N'($urandom_range(0, 20));
        for (int i = 0; i < CH; i++) duty[i*N +: N] = N'($urandom_range(0, 22));
        load = 1;
      end else load = 0;
      if ($urandom_range(0, 39) == 0) en = ~en;
      if (!en) mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 499) == 0) begin
        #2 clr = 1;
        #1 chk("rclr_out", int'(pwm) + int'(sync) + int'(pend), 0);
        tick(1);
        clr = 0;
      end else tick(1);
    end
    load = 0;
    tick(2);
    run_chk = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
